// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard: register file with a tagged per-register write-reservation scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards accepted write-back data to matching read ports in the same cycle.
module register_file_scoreboard #(
  parameter int OPERAND_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int READ_PORTS = 2,
  parameter int TAG_WIDTH = 4,
  parameter int ZERO_REG = 1,
  localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]    rd_addr,
  output logic [READ_PORTS*OPERAND_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]               rd_busy,
  input  logic                                rsv_valid,
  input  logic [ADDR_WIDTH-1:0]               rsv_addr,
  input  logic [TAG_WIDTH-1:0]                rsv_tag,
  input  logic                                wb_valid,
  input  logic [ADDR_WIDTH-1:0]               wb_addr,
  input  logic [TAG_WIDTH-1:0]                wb_tag,
  input  logic [OPERAND_WIDTH-1:0]            wb_data,
  output logic                                wb_stale,
  input  logic                                flush,
  output logic [REG_COUNT-1:0]                busy_vector
);
  logic [OPERAND_WIDTH-1:0] regs [REG_COUNT];
  logic [TAG_WIDTH-1:0] tags [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic wb_zero, wb_accept, rsv_take;
  // Register 0 is never reserved, so it can never accept a write-back and stays 0 from reset.
  assign wb_zero = ZERO_REG != 0 && wb_addr == '0;
  assign wb_accept = wb_valid && busy[wb_addr] && tags[wb_addr] == wb_tag && !wb_zero;
  assign rsv_take = rsv_valid && !flush && !(ZERO_REG != 0 && rsv_addr == '0);
  assign busy_vector = busy;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      wb_stale <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      wb_stale <= wb_valid && !wb_accept && !wb_zero;
      if (wb_accept) regs[wb_addr] <= wb_data;
      if (rsv_take) tags[rsv_addr] <= rsv_tag;
      for (int i = 0; i < REG_COUNT; i++)
        busy[i] <= !flush && (rsv_take && rsv_addr == ADDR_WIDTH'(i) ? 1'b1 :
                              busy[i] && !(wb_accept && wb_addr == ADDR_WIDTH'(i)));
    end
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_WB_BYPASS_EN
    logic fwd;
    assign fwd = wb_accept && wb_addr == a;
    assign rd_data[p*OPERAND_WIDTH +: OPERAND_WIDTH] = fwd ? wb_data : regs[a];
    assign rd_busy[p] = fwd ? rsv_take && rsv_addr == a : busy[a];
`else
    assign rd_data[p*OPERAND_WIDTH +: OPERAND_WIDTH] = regs[a];
    assign rd_busy[p] = busy[a];
`endif
  end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard: directed plus randomized checks against a behavioural scoreboard model.
module tb_register_file_scoreboard;
  localparam int OW = 32, RC = 16, RP = 2, TW = 4, AW = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*OW-1:0] rd_data;
  logic [RP-1:0] rd_busy;
  logic rsv_valid, wb_valid, flush, wb_stale;
  logic [AW-1:0] rsv_addr, wb_addr;
  logic [TW-1:0] rsv_tag, wb_tag;
  logic [OW-1:0] wb_data;
  logic [RC-1:0] busy_vector;
  always #5 clk = ~clk;
  register_file_scoreboard #(.OPERAND_WIDTH(OW), .REG_COUNT(RC), .READ_PORTS(RP), .TAG_WIDTH(TW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_tag(rsv_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_stale(wb_stale), .flush(flush), .busy_vector(busy_vector)
  );
  logic [OW-1:0] m_data [RC];
  logic m_busy [RC];
  logic [TW-1:0] m_tag [RC];
  logic m_stale;
  int vec = 0, miscomp = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miscomp++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < RC; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i] = '0;
    end
    m_stale = 1'b0;
  endtask
  function automatic logic m_acc();
    return wb_valid && m_busy[wb_addr] && m_tag[wb_addr] == wb_tag;
  endfunction
  task automatic check_outputs(string s);
    logic [RC-1:0] bv;
    logic [AW-1:0] a;
    logic [OW-1:0] ed;
    logic eb;
    for (int i = 0; i < RC; i++) bv[i] = m_busy[i];
    chk({s, "/busy_vector"}, 64'(busy_vector), 64'(bv));
    chk({s, "/wb_stale"}, 64'(wb_stale), 64'(m_stale));
    for (int p = 0; p < RP; p++) begin
      a = rd_addr[p*AW +: AW];
      ed = m_data[a];
      eb = m_busy[a];
`ifdef REGFILE_WB_BYPASS_EN
      if (m_acc() && a == wb_addr) begin
        ed = wb_data;
        eb = rsv_valid && !flush && rsv_addr == a;
      end
`endif
      chk($sformatf("%s/rd_data%0d", s, p), 64'(rd_data[p*OW +: OW]), 64'(ed));
      chk($sformatf("%s/rd_busy%0d", s, p), 64'(rd_busy[p]), 64'(eb));
    end
  endtask
  // Check outputs mid-cycle, then advance the model across the clock edge.
  task automatic step(string s);
    logic acc;
    @(negedge clk);
    check_outputs(s);
    @(posedge clk);
    acc = m_acc();
    m_stale = wb_valid && !acc && wb_addr != 0;
    if (acc) begin
      m_data[wb_addr] = wb_data;
      m_busy[wb_addr] = 1'b0;
    end
    if (flush) for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
    else if (rsv_valid && rsv_addr != 0) begin
      m_busy[rsv_addr] = 1'b1;
      m_tag[rsv_addr] = rsv_tag;
    end
    #1;
  endtask
  task automatic idle();
    rsv_valid = 1'b0; rsv_addr = '0; rsv_tag = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_tag = '0; wb_data = '0;
    flush = 1'b0;
  endtask
  task automatic rsv(int a, int t);
    rsv_valid = 1'b1; rsv_addr = AW'(a); rsv_tag = TW'(t);
  endtask
  task automatic wb(int a, int t, logic [OW-1:0] d);
    wb_valid = 1'b1; wb_addr = AW'(a); wb_tag = TW'(t); wb_data = d;
  endtask
  task automatic rd(int a0, int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask
  initial begin
    idle();
    rd(3, 5);
    model_reset();
    #2 check_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    // reset mid-traffic
    rsv(3, 5); rd(3, 3); step("t1_rsv");
    idle(); rst = 1'b0; #1;
    model_reset();
    check_outputs("t1_async_rst");
    chk("t1_bv_zero", 64'(busy_vector), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    wb(3, 5, 32'h123); step("t1_wb");
    idle(); chk("t1_stale", 64'(wb_stale), 64'd1); step("t1_after");
    chk("t1_r3_zero", 64'(rd_data[OW-1:0]), 64'd0);
    // reserve then accepted write-back
    rd(5, 5); rsv(5, 2); step("t2_rsv");
    idle(); wb(5, 2, 32'hDEADBEEF); step("t2_wb");
    idle(); chk("t2_data", 64'(rd_data[OW-1:0]), 64'hDEADBEEF);
    chk("t2_busy", 64'(rd_busy[0]), 64'd0);
    step("t2_after");
    // WAW: older tag is stale
    rd(7, 0); rsv(7, 1); step("t3_rsv1");
    rsv(7, 3); step("t3_rsv3");
    idle(); wb(7, 1, 32'h11); step("t3_wb_old");
    idle(); chk("t3_stale", 64'(wb_stale), 64'd1);
    chk("t3_busy7", 64'(busy_vector[7]), 64'd1);
    wb(7, 3, 32'h33); step("t3_wb_new");
    idle(); chk("t3_data", 64'(rd_data[OW-1:0]), 64'h33);
    step("t3_after");
    // same-cycle reserve and accepted write-back on one register
    rd(4, 4); rsv(4, 2); step("t4_rsv");
    rsv(4, 6); wb(4, 2, 32'hAA); step("t4_both");
    idle(); chk("t4_data", 64'(rd_data[OW-1:0]), 64'hAA);
    chk("t4_busy", 64'(busy_vector[4]), 64'd1);
    wb(4, 2, 32'hBB); step("t4_wb_stale");
    idle(); chk("t4_stale", 64'(wb_stale), 64'd1);
    step("t4_after");
    // flush drops simultaneous reserve
    rd(1, 9); rsv(1, 1); step("t5_rsv1");
    rsv(2, 1); step("t5_rsv2");
    rsv(9, 2); flush = 1'b1; step("t5_flush");
    idle(); chk("t5_bv_zero", 64'(busy_vector), 64'd0);
    step("t5_after");
    // zero register
    rd(0, 0); rsv(0, 0); step("t6_rsv0");
    idle(); wb(0, 0, 32'h5); step("t6_wb0");
    idle(); chk("t6_stale", 64'(wb_stale), 64'd0);
    chk("t6_r0", 64'(rd_data[OW-1:0]), 64'd0);
    step("t6_after");
    rd(8, 8); rsv(8, 4); step("t6_rsv8");
    idle(); wb(8, 4, 32'h77);
`ifdef REGFILE_WB_BYPASS_EN
    #1 chk("t6_fwd0", 64'(rd_data[OW-1:0]), 64'h77);
    chk("t6_fwd1", 64'(rd_data[2*OW-1:OW]), 64'h77);
`endif
    step("t6_wb8");
    idle(); step("t6_r8");
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rd_addr = (RP*AW)'($urandom);
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom);
      rsv_tag = TW'($urandom_range(0, 3));
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr = AW'($urandom);
      wb_tag = $urandom_range(0, 2) == 0 ? TW'($urandom_range(0, 3)) : m_tag[wb_addr];
      wb_data = $urandom;
      flush = $urandom_range(0, 15) == 0;
      step("rand");
    end
    idle(); step("final");
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end
endmodule
